muldiv_unit: RTL and testbench

- Iterative 32-bit multiply/divide unit in the EX stage, next to the ALU, taking the same A/B operands.
- Implements MIPS MULT, MULTU, DIV and DIVU, and holds the architectural HI and LO registers.
- HI/LO feed the EX result mux for MFHI/MFLO; `busy` drives the hazard unit to stall dependent MFHI/MFLO and new mul/div ops.

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_step.sv | 16 +
 rtl/muldiv_unit.sv | 108 ++++++++++
 tb/tb_muldiv_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and helpers for the multiply/divide unit
package muldiv_pkg;
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;
  localparam logic [4:0] ITER_LAST = 5'd31;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  function automatic logic [31:0] mag(input logic [31:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step (
  input  logic        div_i,
  input  logic [63:0] w_i,
  input  logic [31:0] m_i,
  output logic [63:0] w_o
);
  logic [32:0] sum, trial, diff;
  // multiply keeps the unconsumed multiplier in the low half; divide shifts the dividend into the remainder
  always_comb begin
    sum = {1'b0, w_i[63:32]} + (w_i[0] ? {1'b0, m_i} : 33'd0);
    trial = w_i[63:31];
    diff = trial - {1'b0, m_i};
    w_o = div_i ? {diff[32] ? trial[31:0] : diff[31:0], w_i[30:0], ~diff[32]} : {sum, w_i[31:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            cancel_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] op_q;
  logic sa_q, sb_q, done_q;
  logic [31:0] m_q, hi_q, lo_q;
  logic [63:0] w_q, w_step, prod;
  logic sa, sb, load, fix_wr, mt_ok;
  logic [31:0] ma, mb, quo, rem;
  assign sa = ~op_i[0] & a_i[31];
  assign sb = ~op_i[0] & b_i[31];
  assign ma = mag(a_i, sa);
  assign mb = mag(b_i, sb);
  assign load = state_q == IDLE && start_i && !cancel_i;
  assign fix_wr = state_q == FIX && !cancel_i;
  assign mt_ok = state_q == IDLE && !start_i;
  assign prod = (sa_q ^ sb_q) ? -w_q : w_q;
  // a zero divisor must leave the all-ones quotient untouched, so only real divisors get negated
  assign quo = (sa_q ^ sb_q) && m_q != '0 ? -w_q[31:0] : w_q[31:0];
  assign rem = mag(w_q[63:32], sa_q);
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;
  muldiv_step u_step (
    .div_i(op_q[1]),
    .w_i  (w_q),
    .m_i  (m_q),
    .w_o  (w_step)
  );
  // state and iteration counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  // sequencing: launch from IDLE, 32 iterations, one fixup cycle; cancel always returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = CALC;
        cnt_d = '0;
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == ITER_LAST) state_d = FIX;
      end
      default: state_d = IDLE;
    endcase
    if (cancel_i) begin
      state_d = IDLE;
      cnt_d = '0;
    end
  end
  // operand capture and iteration datapath; HI/LO updated by results or MTHI/MTLO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= OP_MULT;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      m_q <= '0;
      w_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix_wr;
      if (load) begin
        op_q <= op_i;
        sa_q <= sa;
        sb_q <= sb;
        m_q <= op_i[1] ? mb : ma;
        w_q <= {32'd0, op_i[1] ? ma : mb};
      end else if (state_q == CALC) w_q <= w_step;
      if (fix_wr) begin
        hi_q <= op_q[1] ? rem : prod[63:32];
        lo_q <= op_q[1] ? quo : prod[31:0];
      end else if (mt_ok) begin
        if (hi_we_i) hi_q <= wdata_i;
        if (lo_we_i) lo_q <= wdata_i;
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against an arithmetic reference model of the mul/div unit
module tb_muldiv_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cancel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;
  int m_left;
  logic m_done;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic [63:0] r;
  int lat, bcnt, dcnt;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b), .cancel_i(cancel),
    .hi_we_i(hi_we), .lo_we_i(lo_we), .wdata_i(wdata), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    longint px, py;
    longint unsigned ux, uy;
    sx = x;
    sy = y;
    px = sx;
    py = sy;
    ux = x;
    uy = y;
    case (o)
      2'b00: return px * py;
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_hi <= '0;
      m_lo <= '0;
      p_hi <= '0;
      p_lo <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (cancel) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi <= p_hi;
            m_lo <= p_lo;
            m_done <= 1'b1;
          end
        end
      end else if (start && !cancel) begin
        {p_hi, p_lo} <= ref_res(op, a, b);
        m_left <= 33;
      end else if (!start) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      chk("model_busy", 32'(busy), 32'(m_left != 0));
      chk("model_done", 32'(done), 32'(m_done));
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int l, output int bc);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    l = 0;
    bc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      start = 1'b0;
      if (busy) bc++;
      if (done) begin
        l = k;
        break;
      end
    end
    if (l == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
    chk("multu_latency", 32'(lat), 32'd34);
    chk("multu_busy_cycles", 32'(bcnt), 32'd33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, lat, bcnt);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    run_op(2'b11, 32'h1234_5678, 32'd0, lat, bcnt);
    chk("divu_zero_hi", hi, 32'h1234_5678);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, bcnt);
    chk("div_zero_hi", hi, 32'hFFFF_FFFB);
    chk("div_zero_lo", lo, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    chk("div_negb_lo", lo, 32'hFFFF_FFFD);
    chk("div_negb_hi", hi, 32'd1);
    op = 2'b01;
    a = 32'd5;
    b = 32'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'd0);
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) dcnt++;
    end
    chk("cancel_no_done", 32'(dcnt), 32'd0);
    chk("cancel_hi_kept", hi, 32'd1);
    chk("cancel_lo_kept", lo, 32'hFFFF_FFFD);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    op = 2'b11;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 45; k++) begin
      step();
      if (done) dcnt++;
    end
    chk("ignored_start_dones", 32'(dcnt), 32'd1);
    chk("ignored_start_lo", lo, 32'd30);
    chk("ignored_start_hi", hi, 32'd0);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hCAFE_F00D;
    step();
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mt_hi", hi, 32'hCAFE_F00D);
    chk("mt_lo", lo, 32'hCAFE_F00D);
    op = 2'b01;
    a = 32'd2;
    b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    step();
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("mt_busy_hi", hi, 32'hCAFE_F00D);
    chk("mt_busy_lo", lo, 32'hCAFE_F00D);
    repeat (3) step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done) dcnt++;
    end
    chk("rst_no_done", 32'(dcnt), 32'd0);
    r = ref_res(2'b00, 32'hFFFF_FFFD, 32'd7);
    chk("model_pin_mult", r[31:0], 32'hFFFF_FFEB);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
